axi_dma_copy: RTL and testbench

// AXI4 master that copies a block of 32-bit words from one address to another.

---
 rtl/axi_dma_copy_if.sv | 51 +++++
 rtl/axi_dma_copy.sv | 197 +++++++++++++++++++
 tb/tb_axi_dma_copy.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_dma_copy_if.sv
// AXI4 bus bundle between the copy engine (master) and memory (slave).
// Signal prefixes: m_ driven by the master, s_ driven by the slave.
interface axi_dma_copy_if;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        s_rvalid;
  logic        m_rready;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_awvalid;
  logic        s_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast;
  logic        m_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        m_bready;

  modport master (
    output m_araddr, m_arlen, m_arsize, m_arburst,
    output m_arvalid, m_rready,
    output m_awaddr, m_awlen, m_awsize, m_awburst,
    output m_awvalid, m_wdata, m_wstrb, m_wlast,
    output m_wvalid, m_bready,
    input  s_arready, s_rdata, s_rresp, s_rlast,
    input  s_rvalid, s_awready, s_wready,
    input  s_bresp, s_bvalid
  );

  modport slave (
    input  m_araddr, m_arlen, m_arsize, m_arburst,
    input  m_arvalid, m_rready,
    input  m_awaddr, m_awlen, m_awsize, m_awburst,
    input  m_awvalid, m_wdata, m_wstrb, m_wlast,
    input  m_wvalid, m_bready,
    output s_arready, s_rdata, s_rresp, s_rlast,
    output s_rvalid, s_awready, s_wready,
    output s_bresp, s_bvalid
  );
endinterface

// File: rtl/axi_dma_copy.sv
// AXI4 block-copy master: one read burst into a local buffer,
// then one write burst out of it, chunk by chunk.
module axi_dma_copy #(
  parameter int BURST_LEN = 16
) (
  input  logic           clk,
  input  logic           reset,
  axi_dma_copy_if.master axi_bus,
  input  logic           start,
  input  logic [31:0]    src_addr,
  input  logic [31:0]    dst_addr,
  input  logic [15:0]    length,
  output logic           busy,
  output logic           done
);

  localparam int AW = $clog2(BURST_LEN);
  localparam int CW = AW + 1;
  localparam logic [16:0] LP_BL = 17'(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_ADDR,
    S_WR_DATA,
    S_WR_RESP,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [29:0]   r_src;
  logic [29:0]   r_dst;
  logic [15:0]   r_rem;
  logic [CW-1:0] r_beat;
  logic          r_done;
  logic [31:0]   r_buf [BURST_LEN];

  logic [16:0]   w_src_room;
  logic [16:0]   w_dst_room;
  logic [16:0]   w_c0;
  logic [16:0]   w_c1;
  logic [16:0]   w_c2;
  logic [16:0]   w_c3;
  logic [CW-1:0] w_chunk;
  logic [CW-1:0] w_last_beat;
  logic          w_beat_last;

  logic w_arvalid;
  logic w_rready;
  logic w_awvalid;
  logic w_wvalid;
  logic w_wlast;
  logic w_bready;
  logic w_unused;

  // Words left before each side's next 4KB page (1024 words)
  assign w_src_room = 17'd1024 - {7'd0, r_src[9:0]};
  assign w_dst_room = 17'd1024 - {7'd0, r_dst[9:0]};

  assign w_c0 = {1'b0, r_rem};
  assign w_c1 = (w_c0 > LP_BL) ? LP_BL : w_c0;
  assign w_c2 = (w_c1 > w_src_room) ? w_src_room : w_c1;
  assign w_c3 = (w_c2 > w_dst_room) ? w_dst_room : w_c2;

  assign w_chunk     = w_c3[CW-1:0];
  assign w_last_beat = w_chunk - 1'b1;
  assign w_beat_last = (r_beat == w_last_beat);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_arvalid = 1'b0;
    w_rready  = 1'b0;
    w_awvalid = 1'b0;
    w_wvalid  = 1'b0;
    w_wlast   = 1'b0;
    w_bready  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (length == 16'd0) ? S_DONE : S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        w_arvalid = 1'b1;
        if (axi_bus.s_arready) w_next = S_RD_DATA;
      end
      S_RD_DATA: begin
        w_rready = 1'b1;
        if (axi_bus.s_rvalid && w_beat_last) w_next = S_WR_ADDR;
      end
      S_WR_ADDR: begin
        w_awvalid = 1'b1;
        if (axi_bus.s_awready) w_next = S_WR_DATA;
      end
      S_WR_DATA: begin
        w_wvalid = 1'b1;
        w_wlast  = w_beat_last;
        if (axi_bus.s_wready && w_beat_last) w_next = S_WR_RESP;
      end
      S_WR_RESP: begin
        w_bready = 1'b1;
        if (axi_bus.s_bvalid) begin
          w_next = (r_rem == 16'(w_chunk)) ? S_DONE : S_RD_ADDR;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src  <= '0;
      r_dst  <= '0;
      r_rem  <= '0;
      r_beat <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src  <= src_addr[31:2];
            r_dst  <= dst_addr[31:2];
            r_rem  <= length;
            r_beat <= '0;
          end
        end
        S_RD_DATA: begin
          if (axi_bus.s_rvalid) begin
            r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
          end
        end
        S_WR_DATA: begin
          if (axi_bus.s_wready) begin
            r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
          end
        end
        S_WR_RESP: begin
          if (axi_bus.s_bvalid) begin
            r_src <= r_src + 30'(w_chunk);
            r_dst <= r_dst + 30'(w_chunk);
            r_rem <= r_rem - 16'(w_chunk);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_RD_DATA && axi_bus.s_rvalid) begin
      r_buf[r_beat[AW-1:0]] <= axi_bus.s_rdata;
    end
  end

  assign axi_bus.m_araddr  = {r_src, 2'b00};
  assign axi_bus.m_arlen   = 8'(w_last_beat);
  assign axi_bus.m_arsize  = 3'd2;
  assign axi_bus.m_arburst = 2'b01;
  assign axi_bus.m_arvalid = w_arvalid;
  assign axi_bus.m_rready  = w_rready;
  assign axi_bus.m_awaddr  = {r_dst, 2'b00};
  assign axi_bus.m_awlen   = 8'(w_last_beat);
  assign axi_bus.m_awsize  = 3'd2;
  assign axi_bus.m_awburst = 2'b01;
  assign axi_bus.m_awvalid = w_awvalid;
  assign axi_bus.m_wdata   = r_buf[r_beat[AW-1:0]];
  assign axi_bus.m_wstrb   = 4'hF;
  assign axi_bus.m_wlast   = w_wlast;
  assign axi_bus.m_wvalid  = w_wvalid;
  assign axi_bus.m_bready  = w_bready;

  assign busy = (r_state != S_IDLE);
  assign done = r_done;

  // Responses are deliberately not reported
  assign w_unused = ^{axi_bus.s_rresp, axi_bus.s_rlast,
                      axi_bus.s_bresp, w_c3[16:CW]};

endmodule

// File: tb/tb_axi_dma_copy.sv
// Bench for axi_dma_copy: stalling AXI slave, bus monitor and
// a chunking model computed from the copy rules.
module tb_axi_dma_copy;

  localparam int BL  = 16;
  localparam int LIM = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;

  axi_dma_copy_if bus ();

  axi_dma_copy #(.BURST_LEN(BL)) dut (
    .clk      (clk),
    .reset    (reset),
    .axi_bus  (bus),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          beats;
  } burst_t;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    int          stall;
    bit          poke;
    int          exp_nb;
    int          exp_first;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;
  int tmo = 0;
  int id = 0;
  int stall_max = 0;
  bit poke = 0;

  burst_t ar_q[$];
  burst_t aw_q[$];
  logic [63:0] wmem [logic [29:0]];
  int r_cnt = 0, w_cnt = 0, b_cnt = 0, done_cnt = 0;
  int both_cnt = 0, stab_err = 0, cross_err = 0, proto_err = 0;
  int b_ar, b_aw, b_r, b_w, b_b, b_done;

  function automatic logic [31:0] src_word(logic [29:0] wa);
    return ({wa, 2'b00} * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Bus monitor, sampled on the falling edge
  logic        p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
  logic [31:0] p_araddr, p_awaddr, p_wdata;
  logic [7:0]  p_arlen, p_awlen;
  logic        p_wlast;
  logic [29:0] mon_wa;
  int          wb, wlen;

  always @(negedge clk) begin
    burst_t b;
    if (reset) begin
      p_arv = 0; p_awv = 0; p_wv = 0;
    end else begin
      if (bus.m_arvalid && bus.m_awvalid) both_cnt++;
      if (p_arv && !p_arr && (!bus.m_arvalid ||
          bus.m_araddr != p_araddr || bus.m_arlen != p_arlen))
        stab_err++;
      if (p_awv && !p_awr && (!bus.m_awvalid ||
          bus.m_awaddr != p_awaddr || bus.m_awlen != p_awlen))
        stab_err++;
      if (p_wv && !p_wr && (!bus.m_wvalid ||
          bus.m_wdata != p_wdata || bus.m_wlast != p_wlast))
        stab_err++;
      if (bus.m_arvalid && bus.s_arready) begin
        b.addr = bus.m_araddr;
        b.beats = int'(bus.m_arlen) + 1;
        ar_q.push_back(b);
        if (bus.m_arsize != 3'd2 || bus.m_arburst != 2'b01) proto_err++;
        if (int'(bus.m_araddr[11:0]) + b.beats * 4 > 4096) cross_err++;
      end
      if (bus.s_rvalid && bus.m_rready) r_cnt++;
      if (bus.m_awvalid && bus.s_awready) begin
        b.addr = bus.m_awaddr;
        b.beats = int'(bus.m_awlen) + 1;
        aw_q.push_back(b);
        if (bus.m_awsize != 3'd2 || bus.m_awburst != 2'b01) proto_err++;
        if (int'(bus.m_awaddr[11:0]) + b.beats * 4 > 4096) cross_err++;
        mon_wa = bus.m_awaddr[31:2];
        wb = 0;
        wlen = int'(bus.m_awlen);
      end
      if (bus.m_wvalid && bus.s_wready) begin
        w_cnt++;
        if (bus.m_wlast != (wb == wlen)) proto_err++;
        if (bus.m_wstrb != 4'hF) proto_err++;
        wmem[mon_wa] = {32'(id), bus.m_wdata};
        mon_wa = mon_wa + 30'd1;
        wb++;
      end
      if (bus.s_bvalid && bus.m_bready) b_cnt++;
      if (done) done_cnt++;
      p_arv = bus.m_arvalid; p_arr = bus.s_arready;
      p_araddr = bus.m_araddr; p_arlen = bus.m_arlen;
      p_awv = bus.m_awvalid; p_awr = bus.s_awready;
      p_awaddr = bus.m_awaddr; p_awlen = bus.m_awlen;
      p_wv = bus.m_wvalid; p_wr = bus.s_wready;
      p_wdata = bus.m_wdata; p_wlast = bus.m_wlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stall();
    int s;
    s = (stall_max == 0) ? 0 : int'($urandom_range(stall_max, 0));
    repeat (s) tick();
  endtask

  task automatic snap();
    b_ar = ar_q.size(); b_aw = aw_q.size();
    b_r = r_cnt; b_w = w_cnt; b_b = b_cnt; b_done = done_cnt;
  endtask

  // Slave side of one read+write burst pair; arvalid is already high
  task automatic serve_burst(input int abort_w, output bit aborted);
    logic [29:0] ra;
    int n, t;
    aborted = 0;
    stall();
    ra = bus.m_araddr[31:2];
    n = int'(bus.m_arlen) + 1;
    bus.s_arready = 1;
    tick();
    bus.s_arready = 0;
    for (int i = 0; i < n; i++) begin
      stall();
      bus.s_rvalid = 1;
      bus.s_rdata = src_word(ra + 30'(i));
      bus.s_rlast = (i == n - 1);
      t = 0;
      while (!bus.m_rready && t < LIM) begin tick(); t++; end
      if (t >= LIM) tmo++;
      if (poke && i == 1) begin
        start = 1; src_addr = 32'h0BAD_0000; length = 16'd3;
      end
      tick();
      bus.s_rvalid = 0; bus.s_rlast = 0; start = 0;
    end
    t = 0;
    while (!bus.m_awvalid && t < LIM) begin tick(); t++; end
    if (t >= LIM) tmo++;
    stall();
    n = int'(bus.m_awlen) + 1;
    bus.s_awready = 1;
    tick();
    bus.s_awready = 0;
    for (int i = 0; i < n; i++) begin
      if (i == abort_w) begin aborted = 1; return; end
      stall();
      bus.s_wready = 1;
      t = 0;
      while (!bus.m_wvalid && t < LIM) begin tick(); t++; end
      if (t >= LIM) tmo++;
      tick();
      bus.s_wready = 0;
    end
    stall();
    bus.s_bvalid = 1;
    bus.s_bresp = 2'b00;
    t = 0;
    while (!bus.m_bready && t < LIM) begin tick(); t++; end
    if (t >= LIM) tmo++;
    tick();
    bus.s_bvalid = 0;
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d,
                          input int len, input int abort_w,
                          output bit aborted);
    int t;
    aborted = 0;
    id++;
    snap();
    start = 1; src_addr = s; dst_addr = d; length = 16'(len);
    tick();
    start = 0;
    for (int k = 0; k < 100; k++) begin
      t = 0;
      while (!bus.m_arvalid && !done && t < LIM) begin tick(); t++; end
      if (t >= LIM) begin tmo++; break; end
      if (done) break;
      serve_burst(abort_w, aborted);
      if (aborted) return;
    end
    repeat (3) tick();
  endtask

  // Expected bursts from the chunking rules, then data/beat checks
  task automatic check_copy(input string nm, input logic [31:0] s,
                            input logic [31:0] d, input int len);
    logic [29:0] sw, dw;
    int rem, c, room, nb, bad_ar, bad_aw, bad_d;
    logic [29:0] key;
    sw = s[31:2]; dw = d[31:2];
    rem = len; nb = 0; bad_ar = 0; bad_aw = 0; bad_d = 0;
    while (rem > 0) begin
      c = (rem > BL) ? BL : rem;
      room = 1024 - int'(sw[9:0]);
      if (c > room) c = room;
      room = 1024 - int'(dw[9:0]);
      if (c > room) c = room;
      if (b_ar + nb >= ar_q.size() ||
          ar_q[b_ar + nb].addr != {sw, 2'b00} ||
          ar_q[b_ar + nb].beats != c) bad_ar++;
      if (b_aw + nb >= aw_q.size() ||
          aw_q[b_aw + nb].addr != {dw, 2'b00} ||
          aw_q[b_aw + nb].beats != c) bad_aw++;
      nb++;
      sw = sw + 30'(c);
      dw = dw + 30'(c);
      rem -= c;
    end
    for (int i = 0; i < len; i++) begin
      key = d[31:2] + 30'(i);
      if (!wmem.exists(key)) bad_d++;
      else if (wmem[key] != {32'(id), src_word(s[31:2] + 30'(i))}) bad_d++;
    end
    if (r_cnt - b_r != len) bad_d++;
    if (w_cnt - b_w != len) bad_d++;
    if (b_cnt - b_b != nb) bad_d++;
    if (aw_q.size() - b_aw != nb) bad_aw++;
    chk({nm, "_ar_n"}, ar_q.size() - b_ar, nb);
    chk({nm, "_ar_bursts"}, bad_ar, 0);
    chk({nm, "_aw_bursts"}, bad_aw, 0);
    chk({nm, "_data"}, bad_d, 0);
    chk({nm, "_done_once"}, done_cnt - b_done, 1);
    chk({nm, "_idle"}, busy, 0);
  endtask

  vec_t tbl[6];

  initial begin
    bit ab;
    logic [31:0] rs, rd;
    int rl;
    tbl[0] = '{32'h0000_1000, 32'h0000_2000, 8, 0, 0, 1, 8};
    tbl[1] = '{32'h0001_0000, 32'h0002_0000, 40, 0, 0, 3, 16};
    tbl[2] = '{32'h0000_0FF8, 32'h0000_5000, 6, 0, 0, 2, 2};
    tbl[3] = '{32'h0000_3000, 32'h0000_7F20, 60, 5, 0, 5, 16};
    tbl[4] = '{32'hFFFF_FFF0, 32'h0000_0100, 8, 2, 0, 2, 4};
    tbl[5] = '{32'h0000_4003, 32'h0000_6002, 20, 3, 1, 2, 16};

    reset = 1; start = 0;
    src_addr = 0; dst_addr = 0; length = 0;
    bus.s_arready = 0; bus.s_rvalid = 0; bus.s_rdata = 0;
    bus.s_rresp = 0; bus.s_rlast = 0; bus.s_awready = 0;
    bus.s_wready = 0; bus.s_bvalid = 0; bus.s_bresp = 0;
    repeat (3) tick();
    chk("reset_outs", {busy, done, bus.m_arvalid, bus.m_awvalid,
        bus.m_wvalid, bus.m_wlast, bus.m_rready, bus.m_bready}, 0);
    chk("reset_araddr", bus.m_araddr, 0);
    reset = 0;
    tick();

    foreach (tbl[v]) begin
      stall_max = tbl[v].stall;
      poke = tbl[v].poke;
      run_copy(tbl[v].src, tbl[v].dst, tbl[v].len, -1, ab);
      poke = 0;
      chk($sformatf("vec%0d_nb", v), ar_q.size() - b_ar, tbl[v].exp_nb);
      chk($sformatf("vec%0d_first", v),
          (ar_q.size() > b_ar) ? ar_q[b_ar].beats : -1,
          tbl[v].exp_first);
      check_copy($sformatf("vec%0d", v), tbl[v].src, tbl[v].dst,
                 tbl[v].len);
    end

    // Zero length, plus a start while busy
    snap();
    start = 1; src_addr = 32'h100; dst_addr = 32'h200; length = 0;
    tick();
    chk("len0_cyc1", {busy, done}, 2'b10);
    length = 16'd4;
    tick();
    start = 0;
    chk("len0_cyc2", {busy, done}, 2'b01);
    tick();
    chk("len0_cyc3", {busy, done}, 2'b00);
    repeat (20) tick();
    chk("len0_noaxi", (ar_q.size() - b_ar) + (aw_q.size() - b_aw)
        + (done_cnt - b_done), 1);

    // Reset in the middle of the write burst
    stall_max = 0;
    run_copy(32'h0000_1000, 32'h0000_2000, 16, 3, ab);
    reset = 1;
    tick();
    chk("midrst_outs", {ab, busy, done, bus.m_arvalid, bus.m_awvalid,
        bus.m_wvalid, bus.m_wlast, bus.m_rready, bus.m_bready},
        9'h100);
    reset = 0;
    tick();
    run_copy(32'h0000_1000, 32'h0000_2000, 16, -1, ab);
    check_copy("after_rst", 32'h0000_1000, 32'h0000_2000, 16);

    for (int k = 0; k < 12; k++) begin
      rs = $urandom;
      rd = $urandom;
      if (k % 3 == 0) rs[11:0] = 12'hFC0 | 12'($urandom_range(63, 0));
      rl = int'($urandom_range(70, 1));
      stall_max = int'($urandom_range(4, 0));
      run_copy(rs, rd, rl, -1, ab);
      check_copy($sformatf("rnd%0d", k), rs, rd, rl);
    end

    chk("ar_aw_overlap", both_cnt, 0);
    chk("valid_stable", stab_err, 0);
    chk("no_4k_cross", cross_err, 0);
    chk("wlast_fields", proto_err, 0);
    chk("timeouts", tmo, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
